// File: rtl/dds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : dds_pkg                                                      |
// | Description : Shared types and constants for the DDS reset/clock slice.    |
// |               Sequencer state encoding, default sequencer timing           |
// |               constants, loss counter width and a saturating increment.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dds_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    REL_CORE  = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_STAGE_GAP_CYCLES   = 64;
  localparam int unsigned DEF_LOSS_FILTER_CYCLES = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES     = 65535;
  localparam int unsigned DEF_PLL_RST_CYCLES     = 16;

  localparam int LOSS_CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + LOSS_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_reset_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : pll_lock_reset_seq_if                                        |
// | Description : Signal bundle between the PLL / DDS datapath and the reset   |
// |               sequencer.                                                   |
// |   lock_i       PLL lock (asynchronous)                                     |
// |   pll_reset_o  PLL reset request                                           |
// |   rst_core_o   phase accumulator / LUT reset                               |
// |   rst_periph_o DAC interface / control register reset                      |
// |   ready_o      sequencer in RUN                                            |
// |   loss_cnt_o   saturating lock-loss event count                            |
// |   master : sequencer side, slave : PLL/datapath side                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pll_lock_reset_seq_if;

  logic                            lock_i;
  logic                            pll_reset_o;
  logic                            rst_core_o;
  logic                            rst_periph_o;
  logic                            ready_o;
  logic [dds_pkg::LOSS_CNT_W-1:0]  loss_cnt_o;

  modport master (
    input  lock_i,
    output pll_reset_o,
    output rst_core_o,
    output rst_periph_o,
    output ready_o,
    output loss_cnt_o
  );

  modport slave (
    output lock_i,
    input  pll_reset_o,
    input  rst_core_o,
    input  rst_periph_o,
    input  ready_o,
    input  loss_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_2ff                                                     |
// | Description : 1-bit two-flop synchronizer with synchronous clear to 0.     |
// |   clk_i  destination clock                                                 |
// |   rst_i  synchronous active-high clear                                     |
// |   d_i    asynchronous input                                                |
// |   q_o    synchronized output                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_2ff (
  input  wire  clk_i,
  input  wire  rst_i,
  input  wire  d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_reset_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_lock_reset_seq                                           |
// | Description : PLL lock watcher and two-stage DDS datapath reset sequencer. |
// |               Pulses the PLL reset at power-up and on lock timeout,        |
// |               debounces lock, releases core then peripheral resets, and    |
// |               re-asserts them on sustained lock loss. Runs on the 27 MHz   |
// |               reference clock.                                             |
// |   clk_i    reference clock                                                 |
// |   reset_i  synchronous active-high reset                                   |
// |   bus      pll_lock_reset_seq_if.master (lock in, resets/status out)       |
// | Build option: PLL_LOSS_COUNT_EN - builds the saturating loss counter;      |
// |               otherwise loss_cnt_o is tied to zero.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pll_lock_reset_seq
  import dds_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
  parameter int unsigned LOSS_FILTER_CYCLES = DEF_LOSS_FILTER_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
  parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES
) (
  input  wire                  clk_i,
  input  wire                  reset_i,
  pll_lock_reset_seq_if.master bus
);

  localparam logic [1:0] c_ST_PLL_RST   = PLL_RST;
  localparam logic [1:0] c_ST_WAIT_LOCK = WAIT_LOCK;
  localparam logic [1:0] c_ST_REL_CORE  = REL_CORE;
  localparam logic [1:0] c_ST_RUN       = RUN;

  localparam int c_PRST_W   = $clog2(PLL_RST_CYCLES + 1);
  localparam int c_STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_GAP_W    = $clog2(STAGE_GAP_CYCLES + 1);
  localparam int c_LOSS_W   = $clog2(LOSS_FILTER_CYCLES + 1);

  localparam logic [c_PRST_W-1:0]   c_PRST_LAST   = c_PRST_W'(PLL_RST_CYCLES - 1);
  localparam logic [c_STABLE_W-1:0] c_STABLE_LAST = c_STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_TMO_W-1:0]    c_TMO_LAST    = c_TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_GAP_W-1:0]    c_GAP_LAST    = c_GAP_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [c_LOSS_W-1:0]   c_LOSS_LAST   = c_LOSS_W'(LOSS_FILTER_CYCLES - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic                  w_stay;
  logic                  w_lock_s;
  logic                  w_sync_clr;

  logic [c_PRST_W-1:0]   r_prst_cnt;
  logic [c_STABLE_W-1:0] r_stable_cnt;
  logic [c_TMO_W-1:0]    r_tmo_cnt;
  logic [c_GAP_W-1:0]    r_gap_cnt;
  logic [c_LOSS_W-1:0]   r_loss_filt_cnt;

  logic                  r_pll_reset;
  logic                  r_rst_core;
  logic                  r_rst_periph;
  logic                  r_ready;

  // The synchronizer is held clear while the PLL is being reset: lock is
  // meaningless then, and the debounce window must start from a clean
  // synchronizer once the PLL is released.
  assign w_sync_clr = reset_i | r_pll_reset;

  sync_2ff u_lock_sync (
    .clk_i (clk_i),
    .rst_i (w_sync_clr),
    .d_i   (bus.lock_i),
    .q_o   (w_lock_s)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_PLL_RST: begin
        if (r_prst_cnt == c_PRST_LAST) w_next = c_ST_WAIT_LOCK;
      end
      c_ST_WAIT_LOCK: begin
        // Stable lock takes priority over a coincident timeout.
        if (w_lock_s && (r_stable_cnt == c_STABLE_LAST)) w_next = c_ST_REL_CORE;
        else if (r_tmo_cnt == c_TMO_LAST)                w_next = c_ST_PLL_RST;
      end
      c_ST_REL_CORE: begin
        if (!w_lock_s)                       w_next = c_ST_WAIT_LOCK;
        else if (r_gap_cnt == c_GAP_LAST)    w_next = c_ST_RUN;
      end
      c_ST_RUN: begin
        if (!w_lock_s && (r_loss_filt_cnt == c_LOSS_LAST)) w_next = c_ST_WAIT_LOCK;
      end
      default: w_next = c_ST_PLL_RST;
    endcase
  end

  assign w_stay = (w_next == r_state);

  // Every counter belongs to one state and is cleared whenever that state is
  // not being held, so each starts from zero on entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state         <= c_ST_PLL_RST;
      r_prst_cnt      <= '0;
      r_stable_cnt    <= '0;
      r_tmo_cnt       <= '0;
      r_gap_cnt       <= '0;
      r_loss_filt_cnt <= '0;
    end else begin
      r_state         <= w_next;
      r_prst_cnt      <= (w_stay && (r_state == c_ST_PLL_RST))
                         ? r_prst_cnt + c_PRST_W'(1) : '0;
      r_tmo_cnt       <= (w_stay && (r_state == c_ST_WAIT_LOCK))
                         ? r_tmo_cnt + c_TMO_W'(1) : '0;
      r_stable_cnt    <= (w_stay && (r_state == c_ST_WAIT_LOCK) && w_lock_s)
                         ? r_stable_cnt + c_STABLE_W'(1) : '0;
      r_gap_cnt       <= (w_stay && (r_state == c_ST_REL_CORE))
                         ? r_gap_cnt + c_GAP_W'(1) : '0;
      r_loss_filt_cnt <= (w_stay && (r_state == c_ST_RUN) && !w_lock_s)
                         ? r_loss_filt_cnt + c_LOSS_W'(1) : '0;
    end
  end

  // Outputs decode the next state so they move on the transition edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pll_reset  <= 1'b1;
      r_rst_core   <= 1'b1;
      r_rst_periph <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_pll_reset  <= (w_next == c_ST_PLL_RST);
      r_rst_core   <= (w_next == c_ST_PLL_RST) || (w_next == c_ST_WAIT_LOCK);
      r_rst_periph <= (w_next != c_ST_RUN);
      r_ready      <= (w_next == c_ST_RUN);
    end
  end

  assign bus.pll_reset_o  = r_pll_reset;
  assign bus.rst_core_o   = r_rst_core;
  assign bus.rst_periph_o = r_rst_periph;
  assign bus.ready_o      = r_ready;

`ifdef PLL_LOSS_COUNT_EN
  logic                  w_loss_event;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  // Only a filtered drop out of RUN counts; a drop during REL_CORE does not.
  assign w_loss_event = (r_state == c_ST_RUN) && (w_next == c_ST_WAIT_LOCK);

  always_ff @(posedge clk_i) begin
    if (reset_i)           r_loss_cnt <= '0;
    else if (w_loss_event) r_loss_cnt <= sat_inc(r_loss_cnt);
  end

  assign bus.loss_cnt_o = r_loss_cnt;
`else
  assign bus.loss_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_reset_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pll_lock_reset_seq                                        |
// | Description : Self-checking bench for pll_lock_reset_seq. A phase/timer    |
// |               model predicts every output each cycle; directed scenarios   |
// |               pin event latencies with literal values; a random lock       |
// |               waveform phase closes out the run.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pll_lock_reset_seq;

  localparam int LS = 16;
  localparam int SG = 8;
  localparam int LF = 4;
  localparam int TO = 64;
  localparam int PR = 4;
`ifdef PLL_LOSS_COUNT_EN
  localparam int c_LOSS_EN = 1;
`else
  localparam int c_LOSS_EN = 0;
`endif

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  pll_lock_reset_seq_if bus ();

  always #5 clk_i = ~clk_i;

  pll_lock_reset_seq #(
    .LOCK_STABLE_CYCLES (LS),
    .STAGE_GAP_CYCLES   (SG),
    .LOSS_FILTER_CYCLES (LF),
    .TIMEOUT_CYCLES     (TO),
    .PLL_RST_CYCLES     (PR)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  // phase: 0 pll reset, 1 waiting for lock, 2 core released, 3 running
  int m_ph = 0, m_t = 0, m_hi = 0, m_lo = 0, m_loss = 0;
  bit m_s1 = 0, m_s2 = 0, m_valid = 0;

  always @(posedge clk_i) begin
    bit ls, clr;
    int nph;
    if (reset_i) begin
      m_ph = 0; m_t = 0; m_hi = 0; m_lo = 0; m_loss = 0;
      m_s1 = 0; m_s2 = 0; m_valid = 1;
    end else begin
      ls  = m_s2;
      clr = (m_ph == 0);
      nph = m_ph;
      case (m_ph)
        0: if (m_t + 1 == PR) nph = 1;
        1: begin
          m_hi = ls ? m_hi + 1 : 0;
          if (m_hi == LS)        nph = 2;
          else if (m_t + 1 == TO) nph = 0;
        end
        2: if (!ls) nph = 1; else if (m_t + 1 == SG) nph = 3;
        default: begin
          m_lo = ls ? 0 : m_lo + 1;
          if (m_lo == LF) begin
            nph = 1;
            if (m_loss < 255) m_loss++;
          end
        end
      endcase
      if (nph != m_ph) begin
        m_ph = nph; m_t = 0; m_hi = 0; m_lo = 0;
      end else begin
        m_t++;
      end
      m_s2 = clr ? 1'b0 : m_s1;
      m_s1 = clr ? 1'b0 : bus.lock_i;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk_i) begin
    logic [11:0] exp_v, act_v;
    if (m_valid) begin
      exp_v = {(m_ph == 0), (m_ph <= 1), (m_ph != 3), (m_ph == 3),
               (c_LOSS_EN != 0) ? 8'(m_loss) : 8'd0};
      act_v = {bus.pll_reset_o, bus.rst_core_o, bus.rst_periph_o, bus.ready_o, bus.loss_cnt_o};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL model_cmp t=%0t: pll/core/periph/ready/loss got %b %b %b %b %0d want %b %b %b %b %0d",
                 $time, act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                 exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.pll_reset_o;
      1:       return bus.rst_core_o;
      2:       return bus.rst_periph_o;
      default: return bus.ready_o;
    endcase
  endfunction

  // Number of rising edges until signal sel shows val (-1 if the bound expires).
  task automatic wait_for(input int sel, input logic val, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (sig(sel) == val) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, rises, core_low;
    logic prev;
    bus.lock_i = 1'b1;
    reset_i    = 1'b1;
    repeat (3) @(negedge clk_i);

    // reset values
    check("rst_pll_reset", bus.pll_reset_o, 1);
    check("rst_core", bus.rst_core_o, 1);
    check("rst_periph", bus.rst_periph_o, 1);
    check("rst_ready", bus.ready_o, 0);
    check("rst_loss", bus.loss_cnt_o, 0);

    // power-up with lock tied high
    reset_i = 1'b0;
    wait_for(0, 1'b0, 50, n);  check("pwr_pll_width", n, PR);
    wait_for(1, 1'b0, 50, n);  check("pwr_core_release", n, 18);
    wait_for(2, 1'b0, 50, n);  check("pwr_periph_gap", n, SG);
    check("pwr_ready", bus.ready_o, 1);

    // short glitch in RUN is filtered
    bus.lock_i = 1'b0;
    repeat (3) @(negedge clk_i);
    bus.lock_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("glitch_ready", bus.ready_o, 1);
    check("glitch_core", bus.rst_core_o, 0);
    check("glitch_loss", bus.loss_cnt_o, 0);

    // sustained loss in RUN, then relock
    bus.lock_i = 1'b0;
    wait_for(1, 1'b1, 20, n);  check("loss_latency", n, 2 + LF);
    check("loss_periph", bus.rst_periph_o, 1);
    check("loss_ready", bus.ready_o, 0);
    check("loss_pll", bus.pll_reset_o, 0);
    check("loss_cnt", bus.loss_cnt_o, c_LOSS_EN);
    repeat (4) @(negedge clk_i);
    bus.lock_i = 1'b1;
    wait_for(1, 1'b0, 40, n);  check("relock_core", n, 2 + LS);
    wait_for(2, 1'b0, 20, n);  check("relock_periph", n, SG);

    // one-cycle reset pulse in RUN
    reset_i    = 1'b1;
    bus.lock_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("midrst_pll", bus.pll_reset_o, 1);
    check("midrst_core", bus.rst_core_o, 1);
    check("midrst_periph", bus.rst_periph_o, 1);
    check("midrst_ready", bus.ready_o, 0);
    check("midrst_loss", bus.loss_cnt_o, 0);
    wait_for(0, 1'b0, 20, n);  check("midrst_pll_width", n, PR);

    // lock toggling (period 20) in WAIT_LOCK never releases, times out twice
    rises = 0; core_low = 0; prev = bus.pll_reset_o;
    for (int k = 0; k < 140; k++) begin
      bus.lock_i = ((k % 20) >= 10);
      @(negedge clk_i);
      if (!bus.rst_core_o) core_low = 1;
      if (bus.pll_reset_o && !prev) rises++;
      prev = bus.pll_reset_o;
    end
    check("toggle_no_release", core_low, 0);
    check("toggle_timeouts", rises, 2);

    // lock never rises: periodic PLL re-reset
    bus.lock_i = 1'b0;
    wait_for(0, 1'b1, 100, n); check("nolock_first_rise", n, 60);
    wait_for(0, 1'b0, 100, n); check("nolock_pulse_width", n, PR);
    wait_for(0, 1'b1, 100, n); check("nolock_gap", n, TO);
    check("nolock_core", bus.rst_core_o, 1);

    // randomized lock waveform with occasional resets, model-checked
    begin
      int cyc;
      logic lv;
      cyc = 0;
      lv  = 1'b1;
      while (cyc < 3000) begin
        int len;
        len = lv ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
        bus.lock_i = lv;
        for (int k = 0; k < len; k++) @(negedge clk_i);
        cyc += len;
        if ($urandom_range(0, 39) == 0) begin
          reset_i = 1'b1;
          repeat (int'($urandom_range(1, 2))) @(negedge clk_i);
          reset_i = 1'b0;
          cyc += 2;
        end
        lv = ~lv;
      end
    end

    repeat (4) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_lock_reset_seq.md
# pll_lock_reset_seq

Reset sequencer directly downstream of `pll_module`. It watches the PLL `lock` output, pulses the PLL `reset` after power-up and after a lock timeout, and debounces lock. It then releases the DDS datapath resets in two stages (core, then peripherals) and re-asserts them on sustained lock loss. It runs on the 27 MHz reference clock, so it keeps operating while the PLL output clock is absent or unstable.

## Interface
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized lock-high cycles required before core reset release.
- `STAGE_GAP_CYCLES`, 64: cycles between core reset release and peripheral reset release.
- `LOSS_FILTER_CYCLES`, 8: consecutive synchronized lock-low cycles, while running, that count as lock loss.
- `TIMEOUT_CYCLES`, 65535: maximum cycles in WAIT_LOCK before the PLL is reset again. Must be greater than `LOCK_STABLE_CYCLES`.
- `PLL_RST_CYCLES`, 16: width of the `pll_reset_o` pulse.
- `clk_i`, in, 1: 27 MHz reference clock (same net as PLL `clkin`).
- `reset_i`, in, 1: reset, synchronous and active-high.
- `lock_i`, in, 1: PLL `lock`, asynchronous to `clk_i`.
- `pll_reset_o`, out, 1: drives PLL `reset`.
- `rst_core_o`, out, 1: active-high reset for the phase accumulator and LUT stage.
- `rst_periph_o`, out, 1: active-high reset for the DAC interface and control registers.
- `ready_o`, out, 1: high only in RUN.
- `loss_cnt_o`, out, 8: saturating count of lock-loss events.

## Operation
- `lock_i` passes through a 2-flop synchronizer; the result is `lock_s`. All decisions use `lock_s` only.
- State PLL_RST:
  - `pll_reset_o`=1 and all datapath resets=1.
  - Stays for exactly `PLL_RST_CYCLES` cycles, then moves to WAIT_LOCK.
- State WAIT_LOCK:
  - `stable_cnt` increments while `lock_s`=1 and clears to 0 on `lock_s`=0.
  - `tmo_cnt` increments every cycle; both counters clear on entry.
  - When `stable_cnt` reaches `LOCK_STABLE_CYCLES-1` with `lock_s`=1 → REL_CORE.
  - Otherwise, when `tmo_cnt` reaches `TIMEOUT_CYCLES-1` → PLL_RST.
  - If both conditions hit on the same cycle, the stable condition wins.
- State REL_CORE:
  - `rst_core_o`=0 and `rst_periph_o`=1.
  - After `STAGE_GAP_CYCLES` cycles → RUN.
  - `lock_s`=0 here goes to WAIT_LOCK immediately, with `rst_core_o`=1 again. This is not counted as a loss.
- State RUN:
  - Both resets=0 and `ready_o`=1.
  - `loss_cnt` counts consecutive `lock_s`=0 cycles and clears on `lock_s`=1.
  - When it reaches `LOSS_FILTER_CYCLES-1` with `lock_s`=0 → WAIT_LOCK, both resets=1, and `loss_cnt_o` increments (saturating at 255).
  - Shorter lock glitches are ignored.
- Lock loss returns to WAIT_LOCK, not PLL_RST. The PLL is re-reset only via timeout.
- Counter widths are `$clog2(param+1)`. Counters never wrap: each is compared and cleared before reaching its limit.

## Timing
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state transition.
- Reset values (while `reset_i`=1 and on the first edge after it):
  - state=PLL_RST, `pll_reset_o`=1, `rst_core_o`=1, `rst_periph_o`=1, `ready_o`=0, `loss_cnt_o`=0.
  - All counters=0.
- `reset_i` mid-operation has the same effect from any state, on the next edge.
- `pll_reset_o` is high for exactly `PLL_RST_CYCLES` edges counted from the first edge with `reset_i`=0.
- Lock-to-release latency: 2 synchronizer cycles + `LOCK_STABLE_CYCLES` cycles from `lock_i` rising to `rst_core_o` falling.
- `rst_periph_o` falls exactly `STAGE_GAP_CYCLES` cycles after `rst_core_o`; `ready_o` rises on the same edge.
- Loss latency: 2 + `LOSS_FILTER_CYCLES` cycles from `lock_i` falling to the resets rising.

## Configuration
- Macro `PLL_LOSS_COUNT_EN`.
- Defined: the 8-bit saturating loss counter is built and drives `loss_cnt_o`.
- Undefined: no counter logic; `loss_cnt_o` is tied to 8'd0. Sequencing is identical in both builds.

## Structure
- Shared package `dds_pkg`:
  - state enum `seq_state_t` (PLL_RST, WAIT_LOCK, REL_CORE, RUN);
  - default parameter constants;
  - `LOSS_CNT_W`=8.
- One sub-module: `sync_2ff` (1-bit two-flop synchronizer with reset value 0), reusable across the design.

## Test plan
Bench parameters: `LOCK_STABLE_CYCLES`=16, `STAGE_GAP_CYCLES`=8, `LOSS_FILTER_CYCLES`=4, `TIMEOUT_CYCLES`=64, `PLL_RST_CYCLES`=4.
- Power-up, `lock_i` tied high:
  - `pll_reset_o` high for 4 cycles;
  - `rst_core_o` falls 18 cycles after WAIT_LOCK entry;
  - `rst_periph_o`/`ready_o` change 8 cycles later.
- `lock_i` never rises: `pll_reset_o` re-pulses for 4 cycles every 68 cycles; datapath resets stay 1.
- In RUN, `lock_i` low for 3 cycles: no reset change, `loss_cnt_o` stays 0.
- In RUN, `lock_i` low for 10 cycles:
  - both resets rise 6 cycles after the fall, `loss_cnt_o`=1;
  - after relock, normal release resumes.
- `lock_i` toggling with period 20 (high 10) in WAIT_LOCK: never releases; timeout → PLL_RST.
- `reset_i` pulsed for 1 cycle during RUN: next edge gives all resets=1, `pll_reset_o`=1, `loss_cnt_o`=0. Under `PLL_LOSS_COUNT_EN` undefined, `loss_cnt_o`=0 throughout.
